aes_cbc_sequencer: RTL and testbench

- Bus initiator that drives the AES-CBC engine's register port (cs/we/address/write_data/read_data) on behalf of a hardware client, so the client needs no firmware.
- Loads config, key and IV, then streams 128-bit blocks: writes each block, issues NEXT, polls STATUS, reads RESULT, and emits it on a valid/ready output.
- Sits beside the AES-CBC wrapper and is muxed onto its register port.

---
 rtl/aes_cbc_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_aes_cbc_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cbc_sequencer.sv
// Bus initiator for the AES-CBC wrapper register port: loads config, key and IV,
// then streams 128-bit blocks through the engine and returns each result on a valid/ready port.
module aes_cbc_sequencer #(
  parameter int          ADDR_WIDTH        = 32,
  parameter int          DATA_WIDTH        = 32,
  parameter logic [31:0] ADDR_CTRL         = 32'h20,
  parameter logic [31:0] ADDR_STATUS       = 32'h24,
  parameter logic [31:0] ADDR_CONFIG       = 32'h28,
  parameter logic [31:0] ADDR_KEY_START    = 32'h40,
  parameter logic [31:0] ADDR_BLOCK_START  = 32'h80,
  parameter logic [31:0] ADDR_IV_START     = 32'h110,
  parameter logic [31:0] ADDR_RESULT_START = 32'h100,
  parameter int          SETTLE            = 3,
  parameter int          TIMEOUT           = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  encdec,
  input  logic                  keylen,
  input  logic [255:0]          key,
  input  logic [127:0]          iv,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cs,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data
);

  localparam int CNT_W = $clog2(TIMEOUT + SETTLE + 8) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_KEY, S_INIT, S_SETTLE_I, S_POLL_I, S_IV, S_WAIT_IN,
    S_BLK, S_NEXT, S_SETTLE_N, S_POLL_N, S_RES, S_OUT, S_DONE
  } state_t;

  // A zero settle time skips the settle states entirely.
  localparam state_t AFTER_INIT = (SETTLE == 0) ? S_POLL_I : S_SETTLE_I;
  localparam state_t AFTER_NEXT = (SETTLE == 0) ? S_POLL_N : S_SETTLE_N;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cfg_encdec, cfg_keylen;
  logic [7:0][31:0] key_q;
  logic [3:0][31:0] iv_q, blk_q, res_q;
  logic             last_q, err_q;
  logic             timeout_hit;
  logic             bus_cs, bus_we;
  logic [31:0]      bus_addr, bus_wdata;
  logic [2:0]       word;
  logic [1:0]       quad;

  assign word = cnt[2:0];
  assign quad = cnt[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt indexes words in the write/read bursts, counts settle cycles and counts polls.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bus_cs      = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CFG;
          cnt_n   = '0;
        end
      end
      S_CFG: begin
        bus_cs    = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = ADDR_CONFIG;
        bus_wdata = {30'd0, cfg_keylen, cfg_encdec};
        state_n   = S_KEY;
        cnt_n     = '0;
      end
      S_KEY: begin
        bus_cs    = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = ADDR_KEY_START + {27'd0, word, 2'b00};
        bus_wdata = key_q[3'd7 - word];
        if (word == 3'd7) begin
          state_n = S_INIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_INIT: begin
        bus_cs    = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = ADDR_CTRL;
        bus_wdata = 32'h1;
        state_n   = AFTER_INIT;
        cnt_n     = '0;
      end
      S_SETTLE_I, S_SETTLE_N: begin
        if (cnt == CNT_W'(SETTLE - 1)) begin
          state_n = (state == S_SETTLE_I) ? S_POLL_I : S_POLL_N;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_POLL_I, S_POLL_N: begin
        bus_cs   = 1'b1;
        bus_addr = ADDR_STATUS;
        if ((state == S_POLL_I) ? read_data[0] : (read_data[1:0] == 2'b11)) begin
          state_n = (state == S_POLL_I) ? S_IV : S_RES;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_n     = S_IDLE;
          cnt_n       = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_IV: begin
        bus_cs    = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = ADDR_IV_START + {28'd0, quad, 2'b00};
        bus_wdata = iv_q[2'd3 - quad];
        if (quad == 2'd3) begin
          state_n = S_WAIT_IN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          state_n = S_BLK;
          cnt_n   = '0;
        end
      end
      S_BLK: begin
        bus_cs    = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = ADDR_BLOCK_START + {28'd0, quad, 2'b00};
        bus_wdata = blk_q[2'd3 - quad];
        if (quad == 2'd3) begin
          state_n = S_NEXT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_NEXT: begin
        bus_cs    = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = ADDR_CTRL;
        bus_wdata = 32'h2;
        state_n   = AFTER_NEXT;
        cnt_n     = '0;
      end
      S_RES: begin
        bus_cs   = 1'b1;
        bus_addr = ADDR_RESULT_START + {28'd0, quad, 2'b00};
        if (quad == 2'd3) begin
          state_n = S_OUT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) state_n = last_q ? S_DONE : S_WAIT_IN;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Stream parameters are latched at start; each block and result word is held here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_encdec <= 1'b0;
      cfg_keylen <= 1'b0;
      key_q      <= '0;
      iv_q       <= '0;
      blk_q      <= '0;
      res_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cfg_encdec <= encdec;
        cfg_keylen <= keylen;
        key_q      <= key;
        iv_q       <= iv;
        err_q      <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
      if (state == S_WAIT_IN && in_valid) begin
        blk_q  <= in_data;
        last_q <= in_last;
      end
      if (state == S_RES) res_q[2'd3 - quad] <= read_data[31:0];
    end
  end

  assign cs         = bus_cs;
  assign we         = bus_we;
  assign address    = ADDR_WIDTH'(bus_addr);
  assign write_data = DATA_WIDTH'(bus_wdata);
  assign in_ready   = (state == S_WAIT_IN);
  assign out_valid  = (state == S_OUT);
  assign out_data   = res_q;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign error      = err_q;

endmodule

// File: tb/tb_aes_cbc_sequencer.sv
// Self-checking bench: an AES-CBC register responder on the bus, directed FIPS/SP800-38A
// streams, timeout and reset cases, and randomized streams against a block-level CBC model.
module tb_aes_cbc_sequencer;

  localparam logic [31:0] A_CTRL   = 32'h20;
  localparam logic [31:0] A_STATUS = 32'h24;
  localparam logic [31:0] A_CONFIG = 32'h28;
  localparam logic [31:0] A_KEY    = 32'h40;
  localparam logic [31:0] A_BLK    = 32'h80;
  localparam logic [31:0] A_IV     = 32'h110;
  localparam logic [31:0] A_RES    = 32'h100;
  localparam int          TMO      = 16;

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, encdec = 1'b0, keylen = 1'b0;
  logic [255:0] key = '0;
  logic [127:0] iv = '0, in_data = '0;
  logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, busy, done, error, cs, we;
  logic [127:0] out_data;
  logic [31:0]  address, write_data, read_data;

  int checks = 0, errors = 0, cyc = 0;
  int status_reads = 0, result_reads = 0, done_count = 0, bus_viol = 0;
  logic [63:0]  wr_log[$];
  logic [7:0]   sbox [256];
  logic [127:0] pt_q [4];
  logic [127:0] known_ct [4];
  bit           stuck = 1'b0;
  int           resp_lat = 0;

  aes_cbc_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .encdec(encdec), .keylen(keylen),
    .key(key), .iv(iv), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .error(error), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // Plain FIPS-197 forward cipher; AES-128 takes the upper half of k.
  function automatic logic [127:0] aes_enc(input logic [255:0] k, input logic kl, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127 - 8*j -: 8] ^ w[j/4][31 - 8*(j%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int j = 0; j < 16; j++) t[j] = sbox[s[4*(((j/4) + (j%4)) % 4) + (j%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd != nr) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31 - 8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Engine stand-in: register file plus a poll-count latency before STATUS reports ready.
  logic [31:0]      r_cfg;
  logic [7:0][31:0] r_key;
  logic [3:0][31:0] r_blk, r_chain, r_res;
  logic             r_valid;
  int               pend;

  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      if (address == A_STATUS)
        read_data = stuck ? 32'h0 : {30'h0, r_valid && (pend == 0), pend == 0};
      else if (address[31:4] == A_RES[31:4])
        read_data = r_res[2'd3 - address[3:2]];
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= 0;
      r_valid <= 1'b0;
    end else if (cs && we) begin
      if (address == A_CONFIG) r_cfg <= write_data;
      else if (address[31:5] == A_KEY[31:5]) r_key[3'd7 - address[4:2]] <= write_data;
      else if (address[31:4] == A_IV[31:4]) r_chain[2'd3 - address[3:2]] <= write_data;
      else if (address[31:4] == A_BLK[31:4]) r_blk[2'd3 - address[3:2]] <= write_data;
      else if (address == A_CTRL) begin
        pend <= resp_lat;
        if (write_data[0]) r_valid <= 1'b0;
        if (write_data[1]) begin
          r_res   <= aes_enc(r_key, r_cfg[1], r_blk ^ r_chain);
          r_chain <= aes_enc(r_key, r_cfg[1], r_blk ^ r_chain);
          r_valid <= 1'b1;
        end
      end
    end else if (cs && !we && address == A_STATUS && pend > 0) begin
      pend <= pend - 1;
    end
  end

  always @(negedge clk) begin
    if (!cs && (we || address != 0 || write_data != 0)) bus_viol++;
    if (cs && we) wr_log.push_back({address, write_data});
    if (cs && !we && address == A_STATUS) status_reads++;
    if (cs && !we && address[31:4] == A_RES[31:4]) result_reads++;
    if (done) done_count++;
  end

  // Runs one full stream from start to done and checks it against the block-level CBC model.
  task automatic applyStimulus(input logic kl, input logic ed, input logic [255:0] k, input logic [127:0] v,
                               input int nblk, input int lat, input int hold_blk, input int hold_n,
                               input bit use_known);
    logic [127:0] chain, expct, saved;
    logic [63:0]  exp_wr[$];
    int k0, c0, n, done0, sr0, rr0;
    bit bad;
    resp_lat = lat;
    wr_log.delete();
    sr0 = status_reads; rr0 = result_reads; done0 = done_count;
    exp_wr.push_back({A_CONFIG, 30'h0, kl, ed});
    for (int i = 0; i < 8; i++) exp_wr.push_back({A_KEY + 32'(4*i), k[255 - 32*i -: 32]});
    exp_wr.push_back({A_CTRL, 32'h1});
    for (int i = 0; i < 4; i++) exp_wr.push_back({A_IV + 32'(4*i), v[127 - 32*i -: 32]});
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 4; i++) exp_wr.push_back({A_BLK + 32'(4*i), pt_q[b][127 - 32*i -: 32]});
      exp_wr.push_back({A_CTRL, 32'h2});
    end
    keylen = kl; encdec = ed; key = k; iv = v; start = 1'b1; k0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_cs_busy_err", {cs, busy, error}, 3'b110);
    chain = v;
    for (int b = 0; b < nblk; b++) begin
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (b == 0) checkOutput("start_to_in_ready", cyc - k0, 19 + lat);
      checkOutput("in_ready_seen", in_ready, 1'b1);
      if (!in_ready) return;
      in_valid = 1'b1; in_data = pt_q[b]; in_last = (b == nblk - 1); c0 = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      checkOutput("blk_to_out_valid", cyc - c0, 14 + lat);
      if (!out_valid) return;
      expct = use_known ? known_ct[b] : aes_enc(k, kl, pt_q[b] ^ chain);
      chain = expct;
      if (b == hold_blk) begin
        saved = out_data; bad = 1'b0;
        for (int i = 0; i < hold_n; i++) begin
          start = (i == 5);
          @(posedge clk); #1;
          if (out_data !== saved || !out_valid || cs || in_ready) bad = 1'b1;
        end
        start = 1'b0;
        checkOutput("hold_stable", bad, 1'b0);
      end
      checkOutput("out_data", out_data, expct);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("done_once", done_count - done0, 1);
    checkOutput("idle_after_done", busy, 1'b0);
    checkOutput("wr_count", wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) checkOutput("wr_seq", wr_log[i], exp_wr[i]);
    checkOutput("status_reads", status_reads - sr0, (nblk + 1) * (lat + 1));
    checkOutput("result_reads", result_reads - rr0, 4 * nblk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sr0, d0, n;
    bit bad;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int p = 0; p < 254; p++) inv = gmul(inv, 8'(x));
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    #2;
    checkOutput("reset_outputs", {cs, we, address, write_data, busy, done, error, out_valid, in_ready, out_data}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] AES-128 FIPS-197 single block");
    pt_q[0] = 128'h00112233445566778899aabbccddeeff;
    known_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    applyStimulus(1'b0, 1'b1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, '0, 1, 0, -1, 0, 1'b1);

    $display("[TB] AES-256 FIPS-197 single block");
    known_ct[0] = 128'h8ea2b7ca516745bfeafc49904b496089;
    applyStimulus(1'b1, 1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  '0, 1, 1, -1, 0, 1'b1);

    $display("[TB] SP800-38A CBC three blocks with output stall");
    pt_q[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    pt_q[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    pt_q[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    known_ct[0] = 128'h7649abac8119b246cee98e9b12e9197d;
    known_ct[1] = 128'h5086cb9b507219ee95db113a917678b2;
    known_ct[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
    applyStimulus(1'b0, 1'b1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h000102030405060708090a0b0c0d0e0f, 3, 2, 0, 20, 1'b1);

    $display("[TB] status never ready");
    stuck = 1'b1; sr0 = status_reads; d0 = done_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("timeout_status_reads", status_reads - sr0, TMO);
    checkOutput("timeout_error_busy", {error, busy}, 2'b10);
    checkOutput("timeout_no_done", done_count - d0, 0);
    stuck = 1'b0;

    $display("[TB] randomized streams");
    for (int r = 0; r < 5; r++) begin
      int nb;
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) pt_q[b] = rand128();
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {rand128(), rand128()}, rand128(),
                    nb, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 8)), 1'b0);
    end

    $display("[TB] reset during result poll");
    resp_lat = 4;
    pt_q[0] = rand128();
    keylen = 1'b0; encdec = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; in_data = pt_q[0]; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (!(cs && !we && address == A_STATUS) && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("reached_result_poll", {cs, we, address}, {1'b1, 1'b0, A_STATUS});
    reset_n = 1'b0;
    #1;
    checkOutput("midop_reset_outputs", {cs, we, address, write_data, busy, done, error, out_valid, in_ready, out_data}, '0);
    bad = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (cs || busy) bad = 1'b1; end
    checkOutput("quiet_in_reset", bad, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    pt_q[0] = rand128();
    pt_q[1] = rand128();
    applyStimulus(1'b1, 1'b0, {rand128(), rand128()}, rand128(), 2, 1, 1, 4, 1'b0);

    checkOutput("bus_idle_values", bus_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
